mem_bus_arbiter: RTL and testbench

//  Shares the single external memory port between the CPU controller (instruction/operand access) and a DMA requester.

---
 rtl/mem_bus_pkg.sv | 31 +++
 rtl/arb_prio_select.sv | 63 ++++++
 rtl/mem_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Package     : mem_bus_pkg
// Description : Shared definitions for the memory bus arbiter. Provides the
//               arbiter state encodings, the bus-owner codes and the default
//               address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    // Default bus geometry
    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_DW = 16;

    // Width of the starvation counter (STARVE_LIMIT range 1..15)
    localparam int STARVE_W = 4;

    // Arbiter state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE    = 2'd0;
    localparam arb_state_t ARB_BUSY    = 2'd1;
    localparam arb_state_t ARB_RELEASE = 2'd2;

    // Bus owner codes
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage : mem_bus_pkg

`default_nettype wire

// File: rtl/arb_prio_select.sv
// ============================================================================
// Module      : arb_prio_select
// Description : Winner selection between CPU and DMA requesters, plus the
//               starvation counter that forces a DMA grant after a run of
//               CPU grants made while DMA was waiting.
// Ports       : clk, reset_n      - clock / asynchronous active-low reset
//               cpu_req, dma_req  - request levels from the two requesters
//               grant_en          - high while the arbiter may make a grant
//               winner            - OWNER_CPU or OWNER_DMA (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_prio_select
    import mem_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic grant_en,
    output logic winner
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("arb_prio_select: STARVE_LIMIT must be in 1..15");
    end

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;
    logic                dma_forced;
    logic                grant_made;

    always_comb begin
        dma_forced = (starve_cnt == LIMIT);
        winner     = OWNER_CPU;
        // DMA only wins when it is actually requesting: either alone, or
        // because the CPU has held the bus long enough while DMA waited.
        if (dma_req && (!cpu_req || dma_forced)) begin
            winner = OWNER_DMA;
        end
    end

    assign grant_made = grant_en && (cpu_req || dma_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_made) begin
            if (winner == OWNER_DMA) begin
                starve_cnt <= '0;
            end else if (dma_req && !dma_forced) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule : arb_prio_select

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one external memory port between the CPU controller
//               and a DMA requester. The winner's address, data and direction
//               are registered onto the memory bus, the memory handshake is
//               run to completion, and a one-cycle ack plus read data is
//               returned to the winner. Each access is followed by a single
//               turnaround cycle before the next grant.
// Ports       : clk, reset_n                    - clock / async active-low reset
//               cpu_req/r_w_n/addr/wdata, cpu_ack - CPU requester side
//               dma_req/r_w_n/addr/wdata, dma_ack - DMA requester side
//               rd_data                         - read data, valid with ack
//               mem_req_n/r_w_n/addr/wdata      - memory request side
//               mem_rdata, mem_ack              - memory response side
//               grant_dma                       - DMA owns the bus
//               bus_err                         - access aborted by timeout
// Config      : MEM_TIMEOUT_EN - when defined, an access with no mem_ack for
//               TIMEOUT_CYC busy cycles is aborted with bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW           = DEFAULT_AW,
    parameter int DW           = DEFAULT_DW,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT_CYC  = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    // CPU requester
    input  logic          cpu_req,
    input  logic          cpu_r_w_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    // DMA requester
    input  logic          dma_req,
    input  logic          dma_r_w_n,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    // Shared read return
    output logic [DW-1:0] rd_data,
    // Memory port
    output logic          mem_req_n,
    output logic          mem_r_w_n,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    // Status
    output logic          grant_dma,
    output logic          bus_err
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
        $error("mem_bus_arbiter: TIMEOUT_CYC must be in 2..255");
    end

    arb_state_t    state;
    logic          owner;
    logic          winner;
    logic          grant_en;
    logic          any_req;
    logic          access_abort;

    logic          sel_r_w_n;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign grant_en = (state == ARB_IDLE);
    assign any_req  = cpu_req | dma_req;

    arb_prio_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_select (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .grant_en (grant_en),
        .winner   (winner)
    );

    // Request fields of whichever requester wins this cycle
    always_comb begin
        sel_r_w_n = cpu_r_w_n;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == OWNER_DMA) begin
            sel_r_w_n = dma_r_w_n;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int            WAIT_W    = 8;
    // wait_cnt holds the number of BUSY cycles already completed, so the
    // TIMEOUT_CYC-th BUSY cycle is the one where it reads TIMEOUT_CYC-1.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            wait_cnt <= '0;
        end else if (state == ARB_BUSY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A mem_ack arriving on the expiry cycle takes precedence over the abort
    assign access_abort = (state == ARB_BUSY) && !mem_ack && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= access_abort;
        end
    end
`else
    assign access_abort = 1'b0;
    assign bus_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            owner     <= OWNER_CPU;
            mem_req_n <= 1'b1;
            mem_r_w_n <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_data   <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            grant_dma <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        mem_r_w_n <= sel_r_w_n;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_req_n <= 1'b0;
                        grant_dma <= (winner == OWNER_DMA);
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack || access_abort) begin
                        if (mem_ack) begin
                            // Writes leave the last read value in place
                            if (mem_r_w_n) begin
                                rd_data <= mem_rdata;
                            end
                        end else begin
                            rd_data <= '0;
                        end
                        cpu_ack   <= (owner == OWNER_CPU);
                        dma_ack   <= (owner == OWNER_DMA);
                        mem_req_n <= 1'b1;
                        grant_dma <= 1'b0;
                        state     <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    // Turnaround cycle: no grant, mem_ack ignored
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : mem_bus_arbiter

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Stimulus pushes the
//               expected grant and response of every access into queues; a
//               monitor pops and compares them when the DUT starts a memory
//               request or pulses an ack. Timeout cases run only when
//               MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_r_w_n, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dma_req, dma_r_w_n, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] rd_data;
    logic          mem_req_n, mem_r_w_n;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          grant_dma, bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (3),
        .TIMEOUT_CYC  (15)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_r_w_n (cpu_r_w_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_r_w_n (dma_r_w_n),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .rd_data   (rd_data),
        .mem_req_n (mem_req_n),
        .mem_r_w_n (mem_r_w_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .grant_dma (grant_dma),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic          dma;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          dma;
        logic [DW-1:0] rd;
        logic          err;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int            checks    = 0;
    int            errors    = 0;
    int            ack_count = 0;
    int            busy_cyc  = 0;
    int            last_busy = 0;
    logic [DW-1:0] exp_rd    = '0;

    // Memory model controls
    int            mem_wait   = 0;
    int            mem_cnt    = 0;
    logic [DW-1:0] mem_data_v = '0;
    logic          force_ack  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: acks after mem_wait cycles of a low mem_req_n
    always @(negedge clk) begin
        if (!reset_n || mem_req_n) begin
            mem_cnt = 0;
            mem_ack = force_ack;
        end else if (mem_cnt >= mem_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_data_v;
        end else begin
            mem_cnt++;
            mem_ack = force_ack;
        end
    end

    // Monitor / scoreboard
    logic prev_req_n = 1'b1;
    always @(negedge clk) begin
        req_t e;
        rsp_t r;
        if (reset_n) begin
            if (prev_req_n && !mem_req_n) begin
                busy_cyc = 1;
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL grant: unexpected memory request addr=%0h", mem_addr);
                end else begin
                    e = req_q.pop_front();
                    check("grant_dma", {31'd0, grant_dma}, {31'd0, e.dma});
                    check("mem_r_w_n", {31'd0, mem_r_w_n}, {31'd0, e.rw});
                    check("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    if (!e.rw) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
                end
            end else if (!mem_req_n) begin
                busy_cyc++;
            end
            if (cpu_ack || dma_ack) begin
                ack_count++;
                last_busy = busy_cyc;
                if (cpu_ack && dma_ack) begin
                    checks++; errors++;
                    $display("FAIL ack: cpu_ack and dma_ack both high");
                end
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack: unexpected ack cpu=%0b dma=%0b", cpu_ack, dma_ack);
                end else begin
                    r = rsp_q.pop_front();
                    check("ack_owner_dma", {31'd0, dma_ack}, {31'd0, r.dma});
                    check("rd_data", {16'd0, rd_data}, {16'd0, r.rd});
                    check("bus_err", {31'd0, bus_err}, {31'd0, r.err});
                end
            end else if (bus_err) begin
                checks++; errors++;
                $display("FAIL bus_err: high without ack, got 1 expected 0");
            end
        end
        prev_req_n = mem_req_n;
    end

    task automatic wait_acks(input int n, input string name);
        int start;
        int cyc;
        start = ack_count;
        cyc   = 0;
        while (ack_count < start + n && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (ack_count < start + n) begin
            checks++; errors++;
            $display("FAIL %s: timed out, got %0d acks expected %0d", name, ack_count - start, n);
        end
    endtask

    // One access from a single requester; returns in IDLE at negedge+1
    task automatic access(input logic dma, input logic rw, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int wait_c,
                          input logic [DW-1:0] rdata, input logic err, input string name);
        mem_wait   = wait_c;
        mem_data_v = rdata;
        req_q.push_back('{dma, rw, addr, wdata});
        if (err) exp_rd = '0;
        else if (rw) exp_rd = rdata;
        rsp_q.push_back('{dma, exp_rd, err});
        if (dma) begin
            dma_r_w_n = rw; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_r_w_n = rw; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        wait_acks(1, name);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk); #1;
        check({name, "_ack_width"}, {30'd0, cpu_ack, dma_ack}, 32'd0);
        check({name, "_grant_clear"}, {31'd0, grant_dma}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cpu_req   = 1'b0; cpu_r_w_n = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dma_req   = 1'b0; dma_r_w_n = 1'b1; dma_addr = '0; dma_wdata = '0;
        mem_ack   = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req_n", {31'd0, mem_req_n}, 32'd1);
        check("rst_mem_r_w_n", {31'd0, mem_r_w_n}, 32'd1);
        check("rst_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check("rst_flags", {28'd0, cpu_ack, dma_ack, grant_dma, bus_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk); #1;

        // 1: CPU read, memory answers after 2 wait cycles
        access(1'b0, 1'b1, 16'h0040, 16'h0000, 2, 16'hBEEF, 1'b0, "cpu_read");

        // 3: DMA write, rd_data must stay BEEF
        access(1'b1, 1'b0, 16'h0100, 16'h1234, 1, 16'hDEAD, 1'b0, "dma_write");

        // 2: both requesting continuously -> C,C,C,D,C,C,C,D
        mem_wait   = 0;
        mem_data_v = 16'hC0DE;
        cpu_r_w_n  = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'h0000;
        dma_r_w_n  = 1'b0; dma_addr = 16'h0300; dma_wdata = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) begin
                req_q.push_back('{1'b1, 1'b0, 16'h0300, 16'h5555});
            end else begin
                req_q.push_back('{1'b0, 1'b1, 16'h0200, 16'h0000});
                exp_rd = 16'hC0DE;
            end
            rsp_q.push_back('{(i % 4 == 3), exp_rd, 1'b0});
        end
        cpu_req = 1'b1;
        dma_req = 1'b1;
        wait_acks(8, "starve_order");
        cpu_req = 1'b0;
        dma_req = 1'b0;

        // 6: mem_ack high through RELEASE and IDLE with no request
        force_ack = 1'b1;
        mem_ack   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("stray_ack_req_n", {29'd0, mem_req_n, cpu_ack, dma_ack}, 32'd4);
        end
        force_ack = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk); #1;

        // 5: asynchronous reset in the middle of an access
        mem_wait = 1000;
        req_q.push_back('{1'b0, 1'b1, 16'h0400, 16'h0000});
        cpu_r_w_n = 1'b1; cpu_addr = 16'h0400; cpu_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("busy_before_reset", {31'd0, mem_req_n}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_req_n", {31'd0, mem_req_n}, 32'd1);
        check("reset_flags", {29'd0, cpu_ack, dma_ack, grant_dma}, 32'd0);
        exp_rd  = '0;
        cpu_req = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("after_reset_idle", {31'd0, mem_req_n}, 32'd1);
        access(1'b0, 1'b1, 16'h0500, 16'h0000, 0, 16'hA5A5, 1'b0, "post_reset");

`ifdef MEM_TIMEOUT_EN
        // 4: no mem_ack -> abort after 15 busy cycles, rd_data cleared
        access(1'b0, 1'b1, 16'h0600, 16'h0000, 1000, 16'h1111, 1'b1, "timeout");
        check("timeout_cycles", last_busy, 32'd15);
        // mem_ack on the 15th busy cycle wins over the timeout
        access(1'b1, 1'b1, 16'h0602, 16'h0000, 14, 16'h2222, 1'b0, "ack_at_expiry");
        check("expiry_cycles", last_busy, 32'd15);
`endif

        repeat (3) @(negedge clk);
        check("queues_drained", req_q.size() + rsp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_bus_arbiter

`default_nettype wire
